// File: rtl/tron_mem_responder.sv
// tron_mem_responder: word-addressed instruction/data store for the Tron CPU bus with programmable wait states.
module tron_mem_responder #(
    parameter int DEPTH       = 256,
    parameter int WAIT_STATES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] addressIn,
    input  logic [15:0] writeData,
    input  logic        memRead,
    input  logic        memWrite,
    input  logic        fetch,
    output logic [15:0] instruction,
    output logic [15:0] readData,
    output logic        ready,
    output logic        busy,
    output logic        addrError,
    output logic        overrun
);
    localparam int AW = $clog2(DEPTH);
    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
    state_t        state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    logic [AW-1:0] idx_q, idx;
    logic [15:0]   wdata_q, wdata, instr_q, rdata_q, rd_val;
    logic          wr_q, fetch_q, ok_q, aerr_q, ovr_q;
    logic          wr, fet, ok, req, accept, enter_resp;
    logic [15:0]   mem_q [DEPTH];

    // With zero wait states the response edge is the accept edge, so request fields bypass their latches.
    always_comb begin
        req        = memRead | memWrite;
        accept     = state_q == IDLE && req;
        idx        = accept ? addressIn[AW-1:0] : idx_q;
        wdata      = accept ? writeData : wdata_q;
        wr         = accept ? memWrite : wr_q;
        fet        = accept ? fetch : fetch_q;
        ok         = accept ? ({1'b0, addressIn} < 17'(DEPTH)) : ok_q;
        rd_val     = ok ? mem_q[idx] : 16'h0000;
        state_d    = state_q == IDLE ? (req ? (WAIT_STATES > 0 ? WAIT : RESP) : IDLE)
                   : state_q == WAIT ? (cnt_q == 4'd0 ? RESP : WAIT) : IDLE;
        cnt_d      = accept ? 4'(WAIT_STATES > 0 ? WAIT_STATES - 1 : 0)
                   : (state_q == WAIT && cnt_q != 4'd0) ? cnt_q - 4'd1 : cnt_q;
        enter_resp = state_d == RESP && state_q != RESP;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            wdata_q <= '0;
            wr_q    <= 1'b0;
            fetch_q <= 1'b0;
            ok_q    <= 1'b0;
            instr_q <= '0;
            rdata_q <= '0;
            aerr_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                idx_q   <= idx;
                wdata_q <= wdata;
                wr_q    <= wr;
                fetch_q <= fet;
                ok_q    <= ok;
                if (!ok) aerr_q <= 1'b1;
            end
            if (req && state_q != IDLE) ovr_q <= 1'b1;
            if (enter_resp) begin
                if (wr || !fet) rdata_q <= rd_val;
                if (!wr && fet) instr_q <= rd_val;
            end
        end
    end

    // Store has no reset; a write lands only on a response edge that is not also a reset edge.
    always_ff @(posedge clk) begin
        if (reset && enter_resp && wr && ok) mem_q[idx] <= wdata;
    end

    assign instruction = instr_q;
    assign readData    = rdata_q;
    assign ready       = state_q == RESP;
    assign busy        = state_q != IDLE;
    assign addrError   = aerr_q;
    assign overrun     = ovr_q;
endmodule
